// File: rtl/keypad_emulator_if.sv
// Key-code push port of the keypad emulator: key code, valid and ready.
interface keypad_emulator_if;
    logic [3:0] key_in;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_in, output key_valid, input key_ready);
    modport slave  (input key_in, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder.
// Queued key codes are pressed one at a time: an optional bounce phase, then a
// hold phase, then a release gap. col_n answers the row strobes combinationally.
module keypad_emulator #(
    parameter int BOUNCE_CYCLES  = 4,
    parameter int HOLD_CYCLES    = 64,
    parameter int RELEASE_CYCLES = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   row_n,
    output logic [3:0]                   col_n,
    keypad_emulator_if.slave             key_if,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy,
    output logic                         key_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      DEPTH       = (AW+1)'(FIFO_DEPTH);
    // A zero-length bounce phase is never entered, so its terminal count is unused.
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_CYCLES > 0) ? (BOUNCE_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BOUNCE, HOLD, RELEASE} state_t;

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic [3:0]                 cur_key;
    logic [FIFO_DEPTH-1:0][3:0] mem;
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic                       push, pop;
    logic                       contact;
    logic [1:0]                 key_row, key_col;
    logic [1:0]                 row_line, col_line;

    // Ready depends only on the occupancy, so a full FIFO never accepts even when popping.
    assign key_if.key_ready = (fifo_count < DEPTH);
    assign push             = key_if.key_valid & key_if.key_ready;
    assign pop              = (state == IDLE) && (fifo_count != '0);
    assign busy             = (state != IDLE) || (fifo_count != '0);

    // FIFO storage; contents are don't-care until written, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= key_if.key_in;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    // Press state, phase counter and the key latched at pop time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_key <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (pop) cur_key <= mem[rd_ptr];
        end
    end

    // Phase sequencing; the counter restarts from zero on every state change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        key_done  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (pop) state_nxt = (BOUNCE_CYCLES > 0) ? BOUNCE : HOLD;
            end
            BOUNCE: begin
                if (cnt == BOUNCE_LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end
            end
            RELEASE: begin
                if (cnt == REL_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    key_done  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Chatter closes the contact on even bounce cycles; hold keeps it closed.
    assign contact = (state == HOLD) || ((state == BOUNCE) && !cnt[0]);

    // Matrix position of the key being pressed.
    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        case (cur_key)
            4'hF: begin key_row = 2'd0; key_col = 2'd0; end
            4'hE: begin key_row = 2'd0; key_col = 2'd1; end
            4'hD: begin key_row = 2'd0; key_col = 2'd2; end
            4'hC: begin key_row = 2'd0; key_col = 2'd3; end
            4'hB: begin key_row = 2'd1; key_col = 2'd0; end
            4'h3: begin key_row = 2'd1; key_col = 2'd1; end
            4'h6: begin key_row = 2'd1; key_col = 2'd2; end
            4'h9: begin key_row = 2'd1; key_col = 2'd3; end
            4'hA: begin key_row = 2'd2; key_col = 2'd0; end
            4'h2: begin key_row = 2'd2; key_col = 2'd1; end
            4'h5: begin key_row = 2'd2; key_col = 2'd2; end
            4'h8: begin key_row = 2'd2; key_col = 2'd3; end
            4'h0: begin key_row = 2'd3; key_col = 2'd0; end
            4'h1: begin key_row = 2'd3; key_col = 2'd1; end
            4'h4: begin key_row = 2'd3; key_col = 2'd2; end
            default: begin key_row = 2'd3; key_col = 2'd3; end
        endcase
    end

    // Row r / column c live on bit 3-r / 3-c of the active-low buses.
    assign row_line = 2'd3 - key_row;
    assign col_line = 2'd3 - key_col;

    // Zero-latency column sense; reset forces the contact open immediately.
    always_comb begin
        col_n = 4'b1111;
        if (contact && !row_n[row_line]) col_n[col_line] = 1'b0;
    end
endmodule
